// File: rtl/multicycle_adder_subtractor.sv
// Chunk-serial adder/subtractor.
// A WIDTH-bit add or subtract is processed CHUNK bits per cycle through a
// rippled carry register. A start/busy/done handshake frames each operation.
// Results and flags update only on the edge that enters DONE.
module multicycle_adder_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] addend1,
  input  logic [WIDTH-1:0] addend2,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // addend2, already inverted for subtract
  logic [WIDTH-1:0] work_q, work_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [31:0]      slice_base;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] result;

  // Current slice arithmetic and the working word with that slice merged in.
  always_comb begin
    slice_base = 32'(cnt_q) * CHUNK;
    a_slice    = a_q[slice_base +: CHUNK];
    b_slice    = b_q[slice_base +: CHUNK];
    slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    result     = work_q;
    result[slice_base +: CHUNK] = slice_sum[CHUNK-1:0];
  end

  // Next-state logic: accept in IDLE/DONE, ripple slices in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = addend1;
          b_d     = addend2 ^ {WIDTH{sign}};
          carry_d = sign;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d  = result;
        carry_d = slice_sum[CHUNK];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          out_d   = result;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (result == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake decoded from state; result and flags come straight from registers.
  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    out       = out_q;
    carry_out = cout_q;
    overflow  = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_multicycle_adder_subtractor.sv
// Bench for multicycle_adder_subtractor: 8/4, 16/1 and 16/16 instances checked
// against an integer-arithmetic reference model.
module tb_multicycle_adder_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, 4-bit chunk instance
  logic       start8, s8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c8, o8, z8;
  logic [7:0] out8;

  // 16-bit instances sharing stimulus: 1-bit chunks and a single full chunk
  logic        start16, s16;
  logic [15:0] a16, b16;
  logic        busy1, done1, c1, o1, z1;
  logic [15:0] out1;
  logic        busyf, donef, cf, of, zf;
  logic [15:0] outf;

  multicycle_adder_subtractor #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .addend1(a8), .addend2(b8), .sign(s8),
    .busy(busy8), .done(done8), .out(out8), .carry_out(c8), .overflow(o8), .zero(z8)
  );

  multicycle_adder_subtractor #(.WIDTH(16), .CHUNK(1)) u_dut16s (
    .clk(clk), .rst(rst), .start(start16), .addend1(a16), .addend2(b16), .sign(s16),
    .busy(busy1), .done(done1), .out(out1), .carry_out(c1), .overflow(o1), .zero(z1)
  );

  multicycle_adder_subtractor #(.WIDTH(16), .CHUNK(16)) u_dut16f (
    .clk(clk), .rst(rst), .start(start16), .addend1(a16), .addend2(b16), .sign(s16),
    .busy(busyf), .done(donef), .out(outf), .carry_out(cf), .overflow(of), .zero(zf)
  );

  logic [7:0] m_out8 = '0;  // result the 8-bit DUT should currently be holding

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: wrap result, unsigned carry/no-borrow, signed range test.
  function automatic void model(input int w, input longint a, input longint b, input bit s,
                                output longint res, output bit c, output bit o, output bit z);
    longint full, half, sa, sb, sr;
    full = (64'sd1 <<< w);
    half = (64'sd1 <<< (w - 1));
    res  = s ? (a - b) : (a + b);
    c    = s ? (a >= b) : (res >= full);
    res  = ((res % full) + full) % full;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    sr   = s ? (sa - sb) : (sa + sb);
    o    = (sr < -half) || (sr > half - 1);
    z    = (res == 0);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    longint er;
    bit ec, eo, ez;
    int lat;
    model(8, longint'(a), longint'(b), s, er, ec, eo, ez);
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    check({tag, " busy after accept"}, 32'(busy8), 32'd1);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = i;
        break;
      end
      check({tag, " out held in run"}, 32'(out8), 32'(m_out8));
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " busy in done"}, 32'(busy8), 32'd0);
    check({tag, " out"}, 32'(out8), 32'(er));
    check({tag, " carry"}, 32'(c8), 32'(ec));
    check({tag, " overflow"}, 32'(o8), 32'(eo));
    check({tag, " zero"}, 32'(z8), 32'(ez));
    m_out8 = 8'(er);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input string tag);
    longint er;
    bit ec, eo, ez;
    int lat1, latf;
    logic [15:0] r1, rf;
    logic [2:0] fl1, flf;
    model(16, longint'(a), longint'(b), s, er, ec, eo, ez);
    @(negedge clk);
    a16 = a; b16 = b; s16 = s; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat1 = -1; latf = -1; r1 = 'x; rf = 'x; fl1 = 'x; flf = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done1 && lat1 < 0) begin
        lat1 = i; r1 = out1; fl1 = {c1, o1, z1};
      end
      if (donef && latf < 0) begin
        latf = i; rf = outf; flf = {cf, of, zf};
      end
    end
    check({tag, " 16/1 latency"}, 32'(lat1), 32'd16);
    check({tag, " 16/1 out"}, 32'(r1), 32'(er));
    check({tag, " 16/1 flags"}, 32'(fl1), 32'({ec, eo, ez}));
    check({tag, " 16/16 latency"}, 32'(latf), 32'd1);
    check({tag, " 16/16 out"}, 32'(rf), 32'(er));
    check({tag, " 16/16 flags"}, 32'(flf), 32'({ec, eo, ez}));
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
    #1;
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset out", 32'(out8), 32'd0);
    check("reset flags", 32'({c8, o8, z8}), 32'd0);
    check("reset 16 out", 32'({out1, outf}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases
    op8(8'h3C, 8'h25, 1'b0, "add 3C+25");
    op8(8'h10, 8'h10, 1'b1, "sub 10-10");
    op8(8'h05, 8'h0A, 1'b1, "sub 05-0A");
    op8(8'h7F, 8'h01, 1'b0, "add 7F+01");
    op8(8'h80, 8'h01, 1'b1, "sub 80-01");

    // Start pulsed during busy is ignored and not queued
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("ignore busy", 32'(busy8), 32'd1);
    @(posedge clk); #1;
    check("ignore done", 32'(done8), 32'd1);
    check("ignore out", 32'(out8), 32'h33);
    @(posedge clk); #1;
    check("ignore no requeue", 32'({busy8, done8}), 32'd0);
    m_out8 = 8'h33;

    // Start held high: back-to-back accepts, done every 3 cycles
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r <= 8; r++) begin
      check("b2b busy", 32'(busy8), 32'(r % 3 != 2));
      check("b2b done", 32'(done8), 32'(r % 3 == 2));
      if (r % 3 == 2) check("b2b out", 32'(out8), 32'h03);
      if (r < 8) begin
        @(posedge clk); #1;
      end
    end
    start8 = 1'b0;
    m_out8 = 8'h03;

    // Asynchronous reset mid-run
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h01; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort out", 32'(out8), 32'd0);
    check("abort flags", 32'({c8, o8, z8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_out8 = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort no done", 32'({busy8, done8}), 32'd0);
    end
    op8(8'h01, 8'h01, 1'b0, "after abort");

    // Randomized 8-bit operations
    for (int i = 0; i < 30; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end

    // 16-bit serial and single-pass instances
    op16(16'hFFFF, 16'h0001, 1'b0, "FFFF+0001");
    op16(16'h8000, 16'h0001, 1'b1, "8000-0001");
    for (int i = 0; i < 6; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_adder_subtractor.md
Name: multicycle_adder_subtractor

Overview:
- Parametrised, chunk-serial add/subtract unit; the sequential successor to the fixed 8-bit combinational adder/subtractor.
- Processes a WIDTH-bit operation in WIDTH/CHUNK cycles, CHUNK bits per cycle, with a rippled carry register.
- Uses a start/busy/done handshake and reports carry, signed overflow and zero flags.
- Intended for the multiplier/divider datapaths, where wide operands make a single-cycle ripple chain too slow.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- CHUNK, 4, bits processed per cycle; must divide WIDTH exactly. CHUNK == WIDTH gives a single-cycle pass.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when accepted (see Behaviour).
- addend1  input  WIDTH  first operand.
- addend2  input  WIDTH  second operand.
- sign  input  1  0 = addend1 + addend2; 1 = addend1 - addend2 (two's complement: invert addend2, carry-in 1).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result and flags are valid.
- out  output  WIDTH  result, held between operations.
- carry_out  output  1  raw carry out of the MSB. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  high when out == 0.

Behaviour:
- Let N = WIDTH/CHUNK.
- Reset: every output is 0. State = IDLE, chunk counter = 0, carry register = 0, working register = 0.
- Reset mid-operation aborts the operation. No done pulse is generated for the aborted operation.

States:
- IDLE: start==1 at a rising edge is accepted. On acceptance:
  - latch addend1 and addend2 ^ {WIDTH{sign}};
  - carry register <= sign; counter <= 0;
  - go to RUN; busy = 1 from the next cycle.
- RUN: on each edge, process slice i = counter, bits [i*CHUNK +: CHUNK]:
  - compute slice = a_slice + b_slice + carry;
  - write the slice result into the working register;
  - carry register <= slice carry; counter++.
  - On the edge that processes slice N-1, go to DONE.
- DONE (one cycle):
  - done = 1, busy = 0;
  - out, carry_out, overflow and zero are updated on the edge that enters DONE;
  - next edge returns to IDLE. A start sampled during DONE is accepted (back-to-back issue); DONE behaves as IDLE for acceptance.

Latency and handshake:
- Start is accepted at edge k. busy is high for cycles k..k+N-1 (i.e., from edge k to edge k+N). done is high from edge k+N to edge k+N+1.
- Latency is N cycles; throughput is one operation per N+1 cycles.
- start while busy==1 is ignored: no queueing, and the latched operands are not disturbed.
- Input operands may change freely after acceptance.

Outputs and flags:
- out and all flags change only on the edge entering DONE (or on reset). They hold otherwise, including during a subsequent RUN.
- overflow = (A[WIDTH-1] == B'[WIDTH-1]) && (out[WIDTH-1] != A[WIDTH-1]), where A is the latched addend1 and B' is the latched, inverted-if-subtract addend2.
- zero is computed from the final result, not from out before the update.
- All arithmetic is modulo 2^WIDTH; carry beyond carry_out is discarded.

Test Plan:
- WIDTH=8, CHUNK=4, 0x3C + 0x25, sign=0 -> done exactly 2 cycles after the accept edge; out=0x61, carry_out=0, overflow=0, zero=0.
- WIDTH=8, CHUNK=4, 0x10 - 0x10, sign=1 -> out=0x00, carry_out=1, zero=1, overflow=0. Then 0x05 - 0x0A -> out=0xFB, carry_out=0, overflow=0.
- WIDTH=8, CHUNK=4, 0x7F + 0x01 -> out=0x80, overflow=1, carry_out=0; then 0x80 - 0x01 -> out=0x7F, overflow=1, carry_out=1.
- WIDTH=8, CHUNK=4: start 0x11+0x22, pulse start with 0xFF+0xFF during busy -> ignored, out=0x33. Start held high through DONE -> second op accepted on the done cycle; done pulses every 3 cycles.
- Reset asserted mid-RUN (asynchronously, between edges) -> busy, done, out and flags are immediately 0, and no done pulse follows. After release, a new op (0x01+0x01) gives out=0x02.
- WIDTH=16, CHUNK=1, 0xFFFF + 0x0001 -> done 16 cycles after accept; out=0x0000, carry_out=1, zero=1, overflow=0. Repeat with CHUNK=16 -> done after 1 cycle with an identical result.
